// File: rtl/sfifo_pkg.sv
// Shared helpers for the synchronous FIFO family: level width, pointer wrap and
// parameter legality checks (also intended for the future async FIFO).
package sfifo_pkg;

    localparam int SFIFO_MIN_DEPTH = 2;
    localparam int SFIFO_MIN_WIDTH = 1;

    function automatic int level_width(input int depth);
        return $clog2(depth + 2);
    endfunction

    // Wrap-around increment that works for any depth, not only powers of two.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return depth >= SFIFO_MIN_DEPTH;
    endfunction

    function automatic bit width_ok(input int width);
        return width >= SFIFO_MIN_WIDTH;
    endfunction

    function automatic bit almost_full_ok(input int lvl, input int depth);
        return (lvl >= 1) && (lvl <= depth + 1);
    endfunction

    function automatic bit almost_empty_ok(input int lvl, input int depth);
        return (lvl >= 0) && (lvl <= depth);
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Simple dual-port storage for sfifo_param: one write port, one registered read
// port. Storage and read register are not reset so the array maps to block RAM.
module sfifo_ram
    import sfifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/sfifo_param.sv
// Parametrised synchronous FIFO with registered output, level and almost flags.
// Optional high-watermark output peak_level when SFIFO_PEAK_LEVEL_EN is defined.
module sfifo_param
    import sfifo_pkg::*;
#(
    parameter int WIDTH              = 32,
    parameter int DEPTH              = 256,
    parameter int ALMOST_FULL_LEVEL  = DEPTH,
    parameter int ALMOST_EMPTY_LEVEL = 1,
    localparam int LW                = level_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] receiver_data,
    input  logic             receiver_valid,
    output logic             receiver_ready,
    output logic [WIDTH-1:0] sender_data,
    output logic             sender_valid,
    input  logic             sender_ready,
    output logic [LW-1:0]    level,
    output logic             almost_full,
    output logic             almost_empty
`ifdef SFIFO_PEAK_LEVEL_EN
    ,
    output logic [LW-1:0]    peak_level
`endif
);

    localparam int PW               = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(ALMOST_FULL_LEVEL);
    localparam logic [LW-1:0] AE_L    = LW'(ALMOST_EMPTY_LEVEL);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("sfifo_param: WIDTH must be >= 1");
        end
        if (!depth_ok(DEPTH)) begin : g_bad_depth
            $error("sfifo_param: DEPTH must be >= 2");
        end
        if (!almost_full_ok(ALMOST_FULL_LEVEL, DEPTH)) begin : g_bad_af
            $error("sfifo_param: ALMOST_FULL_LEVEL must be in 1..DEPTH+1");
        end
        if (!almost_empty_ok(ALMOST_EMPTY_LEVEL, DEPTH)) begin : g_bad_ae
            $error("sfifo_param: ALMOST_EMPTY_LEVEL must be in 0..DEPTH");
        end
    endgenerate

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0] fill_reg, fill_next;
    logic          receiver_ready_reg, receiver_ready_next;
    logic          sender_valid_reg, sender_valid_next;
    logic          write, load;

    always_comb begin
        write = receiver_valid && receiver_ready_reg;
        load  = (fill_reg != '0) && (!sender_valid_reg || sender_ready);

        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (write) begin
            wr_ptr_next = PW'(next_ptr(32'(wr_ptr_reg), DEPTH));
        end
        if (load) begin
            rd_ptr_next = PW'(next_ptr(32'(rd_ptr_reg), DEPTH));
        end

        fill_next = fill_reg;
        if (write && !load) begin
            fill_next = fill_reg + LW'(1);
        end else if (load && !write) begin
            fill_next = fill_reg - LW'(1);
        end

        sender_valid_next = sender_valid_reg;
        if (load) begin
            sender_valid_next = 1'b1;
        end else if (sender_ready) begin
            sender_valid_next = 1'b0;
        end

        receiver_ready_next = (fill_next < DEPTH_L);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            fill_reg           <= '0;
            receiver_ready_reg <= 1'b1;
            sender_valid_reg   <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            fill_reg           <= '0;
            receiver_ready_reg <= 1'b1;
            sender_valid_reg   <= 1'b0;
        end else begin
            wr_ptr_reg         <= wr_ptr_next;
            rd_ptr_reg         <= rd_ptr_next;
            fill_reg           <= fill_next;
            receiver_ready_reg <= receiver_ready_next;
            sender_valid_reg   <= sender_valid_next;
        end
    end

    // The RAM read register is the output register; flush suppresses both ports.
    sfifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (write && !flush),
        .wr_addr (wr_ptr_reg),
        .wr_data (receiver_data),
        .rd_en   (load && !flush),
        .rd_addr (rd_ptr_reg),
        .rd_data (sender_data)
    );

    assign receiver_ready = receiver_ready_reg;
    assign sender_valid   = sender_valid_reg;
    assign level          = fill_reg + LW'(sender_valid_reg);
    assign almost_full    = (level >= AF_L);
    assign almost_empty   = (level <= AE_L);

`ifdef SFIFO_PEAK_LEVEL_EN
    logic [LW-1:0] level_next;
    logic [LW-1:0] peak_level_reg;

    assign level_next = fill_next + LW'(sender_valid_next);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            peak_level_reg <= '0;
        end else if (flush) begin
            peak_level_reg <= '0;
        end else if (level_next > peak_level_reg) begin
            peak_level_reg <= level_next;
        end
    end

    assign peak_level = peak_level_reg;
`endif

endmodule

// File: tb/tb_sfifo_param.sv
// Directed bench for sfifo_param: DEPTH=4 instance for reset/single/fill/flush/
// async-reset scenarios and a DEPTH=3 instance for non-power-of-two wrap streaming.
module tb_sfifo_param;

    localparam int WIDTH = 32;
    localparam int LW4   = $clog2(4 + 2);
    localparam int LW3   = $clog2(3 + 2);

    logic clock;
    logic reset;

    logic             flush_a, rv_a, rr_a, sv_a, sr_a, af_a, ae_a;
    logic [WIDTH-1:0] rd_a, sd_a;
    logic [LW4-1:0]   level_a;

    logic             flush_b, rv_b, rr_b, sv_b, sr_b, af_b, ae_b;
    logic [WIDTH-1:0] rd_b, sd_b;
    logic [LW3-1:0]   level_b;

`ifdef SFIFO_PEAK_LEVEL_EN
    logic [LW4-1:0]   peak_a;
    logic [LW3-1:0]   peak_b;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    sfifo_param #(
        .WIDTH(WIDTH), .DEPTH(4), .ALMOST_FULL_LEVEL(4), .ALMOST_EMPTY_LEVEL(1)
    ) u_dut_a (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush_a),
        .receiver_data  (rd_a),
        .receiver_valid (rv_a),
        .receiver_ready (rr_a),
        .sender_data    (sd_a),
        .sender_valid   (sv_a),
        .sender_ready   (sr_a),
        .level          (level_a),
        .almost_full    (af_a),
        .almost_empty   (ae_a)
`ifdef SFIFO_PEAK_LEVEL_EN
        ,
        .peak_level     (peak_a)
`endif
    );

    sfifo_param #(
        .WIDTH(WIDTH), .DEPTH(3)
    ) u_dut_b (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush_b),
        .receiver_data  (rd_b),
        .receiver_valid (rv_b),
        .receiver_ready (rr_b),
        .sender_data    (sd_b),
        .sender_valid   (sv_b),
        .sender_ready   (sr_b),
        .level          (level_b),
        .almost_full    (af_b),
        .almost_empty   (ae_b)
`ifdef SFIFO_PEAK_LEVEL_EN
        ,
        .peak_level     (peak_b)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int k;
        int sent;
        int rcvd;
        int first_cyc;
        int last_cyc;
        int max_level;
        bit seen;

        reset   = 1'b0;
        flush_a = 1'b0; rv_a = 1'b0; sr_a = 1'b0; rd_a = '0;
        flush_b = 1'b0; rv_b = 1'b0; sr_b = 1'b0; rd_b = '0;

        // Reset held three cycles, then released
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_val("reset_rr", rr_a, 1);
        check_val("reset_sv", sv_a, 0);
        check_val("reset_level", level_a, 0);
        check_val("reset_ae", ae_a, 1);
        check_val("reset_af", af_a, 0);

        // Single word
        sr_a = 1'b1; rv_a = 1'b1; rd_a = 32'hA5A5_0001;
        tick();
        rv_a = 1'b0;
        check_val("single_e1_level", level_a, 1);
        check_val("single_e1_sv", sv_a, 0);
        tick();
        check_val("single_e2_sv", sv_a, 1);
        check_val("single_e2_data", sd_a, 32'hA5A5_0001);
        tick();
        check_val("single_e3_sv", sv_a, 0);
        check_val("single_e3_level", level_a, 0);

        // Fill: offer six words with the sink stalled
        sr_a = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            rv_a = 1'b1;
            rd_a = 32'h10 + 32'(i);
            if (rr_a) accepted++;
            tick();
        end
        rv_a = 1'b0;
        check_val("fill_accepted", 64'(accepted), 5);
        check_val("fill_rr", rr_a, 0);
        check_val("fill_level", level_a, 5);
        check_val("fill_af", af_a, 1);
        check_val("fill_ae", ae_a, 0);

        // Drain in order
        sr_a = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (sv_a) begin
                check_val("drain_data", sd_a, 64'(32'h10 + 32'(k)));
                k++;
            end
            tick();
            if (cyc == 0) check_val("drain_rr_back", rr_a, 1);
        end
        check_val("drain_count", 64'(k), 5);
        check_val("drain_level", level_a, 0);

        // Flush with a concurrent write
        sr_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rv_a = 1'b1;
            rd_a = 32'h20 + 32'(i);
            tick();
        end
        check_val("preflush_level", level_a, 3);
        flush_a = 1'b1; rv_a = 1'b1; rd_a = 32'h0000_DEAD;
        tick();
        flush_a = 1'b0; rv_a = 1'b0;
        check_val("flush_level", level_a, 0);
        check_val("flush_sv", sv_a, 0);
        check_val("flush_rr", rr_a, 1);
        sr_a = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (sv_a) seen = 1'b1;
            tick();
        end
        check_val("flush_no_dead", 64'(seen), 0);

        // Asynchronous reset with level 4
        sr_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rv_a = 1'b1;
            rd_a = 32'h30 + 32'(i);
            tick();
        end
        rv_a = 1'b0;
        check_val("prearst_level", level_a, 4);
        check_val("prearst_af", af_a, 1);
`ifdef SFIFO_PEAK_LEVEL_EN
        check_val("prearst_peak", peak_a, 4);
`endif
        #2 reset = 1'b0;
        #1;
        check_val("arst_rr", rr_a, 1);
        check_val("arst_sv", sv_a, 0);
        check_val("arst_level", level_a, 0);
        check_val("arst_ae", ae_a, 1);
        check_val("arst_af", af_a, 0);
`ifdef SFIFO_PEAK_LEVEL_EN
        check_val("arst_peak", peak_a, 0);
`endif
        @(negedge clock);
        reset = 1'b1;
        tick();

        // DEPTH=3 streaming: both sides always ready
        sr_b = 1'b1;
        sent = 0; rcvd = 0; first_cyc = -1; last_cyc = -1; max_level = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (int'(level_b) > max_level) max_level = int'(level_b);
            if (sv_b) begin
                check_val("wrap_data", sd_b, 64'(rcvd));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                rcvd++;
            end
            rv_b = (sent < 20);
            rd_b = 32'(sent);
            if (rv_b && rr_b) sent++;
            tick();
        end
        rv_b = 1'b0;
        check_val("wrap_count", 64'(rcvd), 20);
        check_val("wrap_gapfree", 64'(last_cyc - first_cyc), 19);
        check_val("wrap_latency", 64'(first_cyc), 2);
        check_val("wrap_max_level", 64'(max_level), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
